// File: rtl/my_mem_ctrl.sv
// Request front-end for my_mem: queues read/write requests, sequences the
// memory strobes one operation at a time and returns parity-checked reads.
module my_mem_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_perr,
  output logic [7:0]        perr_count,
  output logic              mem_write,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W:0]   mem_data_out
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int EW = 1 + ADDR_W + DATA_W;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_CAPT  = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  logic [2:0]        state;
  logic [EW-1:0]     fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              push;
  logic              pop;
  logic              head_write;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_wdata;
  logic              perr;

  assign req_ready = (count != CW'(FIFO_DEPTH));
  assign push      = req_valid && req_ready;
  assign pop       = (state == S_IDLE) && (count != '0);

  assign {head_write, head_addr, head_wdata} = fifo_mem[rd_ptr];

  // Stored parity bit is the XOR of the data bits.
  assign perr = mem_data_out[DATA_W] != ^mem_data_out[DATA_W-1:0];

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {req_write, req_addr, req_wdata};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      mem_write   <= 1'b0;
      mem_read    <= 1'b0;
      mem_address <= '0;
      mem_data_in <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_perr    <= 1'b0;
      perr_count  <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (pop) begin
            mem_address <= head_addr;
            mem_data_in <= head_wdata;
            mem_write   <= head_write;
            mem_read    <= !head_write;
            state       <= head_write ? S_WRITE : S_READ;
          end
        end
        S_WRITE: begin
          mem_write <= 1'b0;
          state     <= S_IDLE;
        end
        S_READ: begin
          mem_read <= 1'b0;
          state    <= S_CAPT;
        end
        S_CAPT: begin
          rsp_rdata <= mem_data_out[DATA_W-1:0];
          rsp_perr  <= perr;
          rsp_valid <= 1'b1;
          if (perr && (perr_count != 8'hFF)) begin
            perr_count <= perr_count + 8'd1;
          end
          state <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          mem_write <= 1'b0;
          mem_read  <= 1'b0;
          rsp_valid <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_my_mem_ctrl.sv
// Directed bench for my_mem_ctrl with a behavioural even-parity my_mem.
// Vector table for write/read traffic plus hand-written corner sequences.
module tb_my_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [15:0] req_addr = '0;
  logic [7:0]  req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [7:0]  rsp_rdata;
  logic        rsp_perr;
  logic [7:0]  perr_count;
  logic        mem_write;
  logic        mem_read;
  logic [15:0] mem_address;
  logic [7:0]  mem_data_in;
  logic [8:0]  mem_data_out = '0;
  logic        force_bad = 1'b0;

  logic [8:0]  mem_arr [0:65535];

  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct {
    logic        write;
    logic        bad;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  exp_rdata;
    logic        exp_perr;
    logic [7:0]  exp_cnt;
  } vec_t;

  vec_t vecs [14];

  my_mem_ctrl #(.FIFO_DEPTH(4), .ADDR_W(16), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_perr(rsp_perr), .perr_count(perr_count),
    .mem_write(mem_write), .mem_read(mem_read),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  // Behavioural my_mem: synchronous write and read, parity in bit 8.
  always @(posedge clk) begin
    if (mem_write) mem_arr[mem_address] <= {^mem_data_in, mem_data_in};
    if (mem_read) mem_data_out <= force_bad ? 9'h1A5 : mem_arr[mem_address];
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic send(input logic w, input logic [15:0] a,
                      input logic [7:0] d);
    int n = 0;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    while (!req_ready && n < 50) begin
      @(negedge clk); n++;
    end
    if (!req_ready) chk("send_timeout", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic get_rsp(input string nm, input logic [7:0] er,
                         input logic ep);
    int n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk); n++;
    end
    if (!rsp_valid) begin
      chk({nm, "_timeout"}, 32'(rsp_valid), 32'd1);
    end else begin
      chk({nm, "_rdata"}, 32'(rsp_rdata), 32'(er));
      chk({nm, "_perr"}, 32'(rsp_perr), 32'(ep));
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready = 1'b0;
      chk({nm, "_drop"}, 32'(rsp_valid), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] addrs [6];
    logic [7:0]  datas [6];
    int seen;
    addrs = '{16'h0040, 16'hBEEF, 16'h7F01, 16'h0003, 16'hC0DE, 16'h5A5A};
    datas = '{8'h3C, 8'hFF, 8'h01, 8'h80, 8'h96, 8'h00};
    for (int i = 0; i < 6; i++) begin
      vecs[i] = '{1'b1, 1'b0, addrs[i], datas[i], 8'h00, 1'b0, 8'h00};
      vecs[i+6] = '{1'b0, 1'b0, addrs[i], 8'h00, datas[i], 1'b0, 8'h00};
    end
    vecs[12] = '{1'b0, 1'b1, addrs[0], 8'h00, 8'hA5, 1'b1, 8'h01};
    vecs[13] = '{1'b0, 1'b0, addrs[1], 8'h00, datas[1], 1'b0, 8'h01};

    // Reset state
    #12;
    chk("rst_mem_write", 32'(mem_write), 0);
    chk("rst_mem_read", 32'(mem_read), 0);
    chk("rst_mem_address", 32'(mem_address), 0);
    chk("rst_mem_data_in", 32'(mem_data_in), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 0);
    chk("rst_rsp_perr", 32'(rsp_perr), 0);
    chk("rst_perr_count", 32'(perr_count), 0);
    chk("rst_req_ready", 32'(req_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (mem_write || mem_read || rsp_valid) seen++;
    end
    chk("idle_no_strobe", 32'(seen), 0);

    // Single write timing
    req_valid = 1'b1; req_write = 1'b1;
    req_addr = 16'h1234; req_wdata = 8'hA5;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("w_e0_mem_write", 32'(mem_write), 0);
    @(negedge clk);
    chk("w_e1_mem_write", 32'(mem_write), 1);
    chk("w_e1_mem_read", 32'(mem_read), 0);
    chk("w_e1_addr", 32'(mem_address), 32'h1234);
    chk("w_e1_data", 32'(mem_data_in), 32'hA5);
    @(negedge clk);
    chk("w_e2_mem_write", 32'(mem_write), 0);
    chk("w_e2_rsp_valid", 32'(rsp_valid), 0);
    chk("w_hold_addr", 32'(mem_address), 32'h1234);
    chk("w_mem_stored", 32'(mem_arr[16'h1234]), 32'h0A5);

    // Table: six writes, six reads, then a forced parity error and a clean read
    for (int i = 0; i < 14; i++) begin
      force_bad = vecs[i].bad;
      send(vecs[i].write, vecs[i].addr, vecs[i].wdata);
      if (!vecs[i].write) begin
        get_rsp($sformatf("vec%0d", i), vecs[i].exp_rdata, vecs[i].exp_perr);
        chk($sformatf("vec%0d_cnt", i), 32'(perr_count),
            32'(vecs[i].exp_cnt));
      end
      force_bad = 1'b0;
    end

    // Capacity: responses stalled, six back-to-back reads
    repeat (3) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      req_valid = 1'b1; req_write = 1'b0;
      req_addr = addrs[i]; req_wdata = 8'h00;
      chk($sformatf("cap_ready%0d", i), 32'(req_ready),
          (i < 5) ? 32'd1 : 32'd0);
      @(posedge clk);
      @(negedge clk);
    end
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      get_rsp($sformatf("cap%0d", i), datas[i], 1'b0);
      if (i == 0) begin
        chk("cap_still_full", 32'(req_ready), 0);
        @(negedge clk);
        chk("cap_ready_back", 32'(req_ready), 1);
      end
    end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid || mem_read) seen++;
    end
    chk("cap_sixth_dropped", 32'(seen), 0);

    // Reset during READ with one more request queued
    req_valid = 1'b1; req_write = 1'b0; req_addr = addrs[2];
    @(posedge clk);
    @(negedge clk);
    req_addr = addrs[3];
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("rr_mem_read", 32'(mem_read), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rr_async_mem_read", 32'(mem_read), 0);
    chk("rr_async_addr", 32'(mem_address), 0);
    chk("rr_async_ready", 32'(req_ready), 1);
    chk("rr_async_cnt", 32'(perr_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid || mem_read || mem_write) seen++;
    end
    chk("rr_nothing_after", 32'(seen), 0);
    chk("rr_perr_count", 32'(perr_count), 0);
    chk("rr_req_ready", 32'(req_ready), 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
